// File: rtl/uart_core.sv
// 8n1 UART transceiver: x16 oversampling strobe, TX/RX state machines, show-ahead RX FIFO.
// Define UART_LOOPBACK_EN to build the internal TX-to-RX loopback path selected by loopback_i.
module uart_core #(
    parameter int RX_FIFO_AW = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    input  logic [15:0] divisor_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        rx_overrun_o,
    output logic        rx_frame_err_o,
    output logic        rx_break_o,
    input  logic        loopback_i
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;
    localparam int FIFO_DEPTH = 1 << RX_FIFO_AW;

    // Divisor 0 reloads 16'hFFFF, giving the 65536-cycle wrap period.
    logic [15:0] baud_cnt_reg;
    logic        strobe;
    assign strobe = (baud_cnt_reg == 16'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i || strobe) baud_cnt_reg <= divisor_i - 16'd1;
        else                 baud_cnt_reg <= baud_cnt_reg - 16'd1;
    end

    logic [1:0] tx_state_reg;
    logic [3:0] tx_tick_reg;
    logic [2:0] tx_bit_reg;
    logic [7:0] tx_shift_reg;
    logic       tx_line_reg;

    assign tx_ready_o = (tx_state_reg == ST_IDLE) & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_reg <= ST_IDLE;
            tx_tick_reg  <= 4'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            tx_line_reg  <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: begin
                    if (tx_valid_i) begin
                        tx_shift_reg <= tx_data_i;
                        tx_tick_reg  <= 4'd0;
                        tx_line_reg  <= 1'b0;
                        tx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (strobe) begin
                        tx_tick_reg <= tx_tick_reg + 4'd1;
                        if (tx_tick_reg == 4'd15) begin
                            tx_line_reg  <= tx_shift_reg[0];
                            tx_bit_reg   <= 3'd0;
                            tx_state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        tx_tick_reg <= tx_tick_reg + 4'd1;
                        if (tx_tick_reg == 4'd15) begin
                            // Shift register keeps the next data bit at index 1.
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            if (tx_bit_reg == 3'd7) begin
                                tx_line_reg  <= 1'b1;
                                tx_state_reg <= ST_STOP;
                            end else begin
                                tx_line_reg <= tx_shift_reg[1];
                                tx_bit_reg  <= tx_bit_reg + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (strobe) begin
                        tx_tick_reg <= tx_tick_reg + 4'd1;
                        if (tx_tick_reg == 4'd15) tx_state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic rx_src;
`ifdef UART_LOOPBACK_EN
    assign rx_src    = loopback_i ? tx_line_reg : uart_rx_i;
    assign uart_tx_o = loopback_i ? 1'b1 : tx_line_reg;
`else
    logic unused_loopback;
    assign unused_loopback = loopback_i;
    assign rx_src    = uart_rx_i;
    assign uart_tx_o = tx_line_reg;
`endif

    // prev_rx resets low so a line held low out of reset never looks like a start edge.
    logic [1:0] sync_reg;
    logic       prev_rx_reg;
    logic       sync_rx;
    assign sync_rx = sync_reg[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg    <= 2'b00;
            prev_rx_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], rx_src};
            if (strobe) prev_rx_reg <= sync_rx;
        end
    end

    logic [1:0] rx_state_reg;
    logic [3:0] rx_tick_reg;
    logic [2:0] rx_bit_reg;
    logic [7:0] rx_shift_reg;
    logic       rx_push_reg;
    logic       rx_frame_err_reg;
    logic       rx_break_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_reg     <= ST_IDLE;
            rx_tick_reg      <= 4'd0;
            rx_bit_reg       <= 3'd0;
            rx_shift_reg     <= 8'd0;
            rx_push_reg      <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rx_break_reg     <= 1'b0;
        end else begin
            rx_push_reg      <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rx_break_reg     <= 1'b0;
            if (strobe) begin
                case (rx_state_reg)
                    ST_IDLE: begin
                        rx_tick_reg <= 4'd0;
                        if (!sync_rx && prev_rx_reg) rx_state_reg <= ST_START;
                    end
                    ST_START: begin
                        rx_tick_reg <= rx_tick_reg + 4'd1;
                        if (rx_tick_reg == 4'd7) begin
                            rx_tick_reg <= 4'd0;
                            rx_bit_reg  <= 3'd0;
                            rx_state_reg <= sync_rx ? ST_IDLE : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        rx_tick_reg <= rx_tick_reg + 4'd1;
                        if (rx_tick_reg == 4'd15) begin
                            rx_shift_reg <= {sync_rx, rx_shift_reg[7:1]};
                            rx_bit_reg   <= rx_bit_reg + 3'd1;
                            if (rx_bit_reg == 3'd7) rx_state_reg <= ST_STOP;
                        end
                    end
                    default: begin
                        rx_tick_reg <= rx_tick_reg + 4'd1;
                        if (rx_tick_reg == 4'd15) begin
                            rx_state_reg <= ST_IDLE;
                            if (sync_rx)                    rx_push_reg      <= 1'b1;
                            else if (rx_shift_reg == 8'h00) rx_break_reg     <= 1'b1;
                            else                            rx_frame_err_reg <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Asynchronous read keeps the head byte visible whenever the FIFO is non-empty.
    logic [7:0]            rx_mem [FIFO_DEPTH];
    logic [RX_FIFO_AW-1:0] rx_wr_ptr_reg;
    logic [RX_FIFO_AW-1:0] rx_rd_ptr_reg;
    logic [RX_FIFO_AW:0]   rx_count_reg;
    logic                  rx_overrun_reg;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic                  fifo_push;

    assign rx_valid_o = (rx_count_reg != '0);
    assign rx_data_o  = rx_mem[rx_rd_ptr_reg];
    assign fifo_full  = rx_count_reg[RX_FIFO_AW];
    assign fifo_pop   = rx_valid_o & rx_ready_i;
    assign fifo_push  = rx_push_reg & (~fifo_full | fifo_pop);

    always_ff @(posedge clk_i) begin
        if (fifo_push) rx_mem[rx_wr_ptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_ptr_reg  <= '0;
            rx_rd_ptr_reg  <= '0;
            rx_count_reg   <= '0;
            rx_overrun_reg <= 1'b0;
        end else begin
            if (fifo_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (fifo_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            rx_count_reg   <= rx_count_reg + {{RX_FIFO_AW{1'b0}}, fifo_push}
                                           - {{RX_FIFO_AW{1'b0}}, fifo_pop};
            rx_overrun_reg <= rx_push_reg & fifo_full & ~fifo_pop;
        end
    end

    assign rx_overrun_o   = rx_overrun_reg;
    assign rx_frame_err_o = rx_frame_err_reg;
    assign rx_break_o     = rx_break_reg;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: random/directed TX and RX frames against a queue model.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int DEPTH   = 16;
    localparam int BIT_CYC = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic [15:0] divisor_i = 16'd4;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        rx_overrun_o;
    logic        rx_frame_err_o;
    logic        rx_break_o;
    logic        loopback_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int mon_ovr = 0, mon_ferr = 0, mon_brk = 0;
    int exp_ovr = 0, exp_ferr = 0, exp_brk = 0;
    logic [7:0] model_q [$];

    uart_core #(.RX_FIFO_AW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .divisor_i(divisor_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .rx_overrun_o(rx_overrun_o),
        .rx_frame_err_o(rx_frame_err_o), .rx_break_o(rx_break_o), .loopback_i(loopback_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_overrun_o)   mon_ovr++;
        if (rx_frame_err_o) mon_ferr++;
        if (rx_break_o)     mon_brk++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_ovr"},  mon_ovr,  exp_ovr);
        check({tag, "_ferr"}, mon_ferr, exp_ferr);
        check({tag, "_brk"},  mon_brk,  exp_brk);
        check({tag, "_valid"}, rx_valid_o, (model_q.size() != 0));
    endtask

    // Transmit one byte and decode the line mid-bit; frame is start, LSB-first data, stop.
    task automatic send_tx(input logic [7:0] b);
        logic [9:0] f;
        int n;
        int ready_low;
        f = {1'b1, b, 1'b0};
        n = 0;
        while (!tx_ready_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check("tx_ready_before", tx_ready_o, 1'b1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'($urandom);
        ready_low = -1;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk_i);
            if (c >= 32 && (c - 32) % BIT_CYC == 0 && (c - 32) / BIT_CYC < 10)
                check($sformatf("tx_%02h_bit%0d", b, (c - 32) / BIT_CYC), uart_tx_o, f[(c - 32) / BIT_CYC]);
            if (ready_low < 0 && tx_ready_o) ready_low = c - 1;
        end
        check("tx_ready_low_len", (ready_low >= 636 && ready_low <= 641), 1'b1);
        $display("tx byte %02h sent, tx_ready_o low for %0d cycles", b, ready_low);
    endtask

    // Drive one serial frame; the model decides push, overrun, break or framing error.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_i = f[i];
            repeat (BIT_CYC) @(negedge clk_i);
        end
        uart_rx_i = 1'b1;
        if (stop_bit) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else                        exp_ovr++;
        end else if (b == 8'h00) begin
            exp_brk++;
        end else begin
            exp_ferr++;
        end
        repeat (8) @(negedge clk_i);
        $display("rx frame %02h stop=%0b driven, model holds %0d bytes", b, stop_bit, model_q.size());
    endtask

    task automatic pop_check(input logic [7:0] exp);
        int n;
        n = 0;
        while (!rx_valid_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("rx_valid", rx_valid_o, 1'b1);
        check("rx_data", rx_data_o, exp);
        $display("rx pop %02h (expected %02h)", rx_data_o, exp);
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_ready_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic drain_model();
        while (model_q.size() != 0) pop_check(model_q.pop_front());
        check("rx_empty_after_drain", rx_valid_o, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int nr;

        // Reset state
        repeat (4) @(negedge clk_i);
        check("rst_tx_line", uart_tx_o, 1'b1);
        check("rst_tx_ready", tx_ready_o, 1'b0);
        check("rst_rx_valid", rx_valid_o, 1'b0);
        check("rst_pulses", {rx_overrun_o, rx_frame_err_o, rx_break_o}, 3'b000);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_tx_ready", tx_ready_o, 1'b1);

        // TX: directed 0xA5 then random bytes
        send_tx(8'hA5);
        for (int i = 0; i < 3; i++) send_tx(8'($urandom));

        // RX: directed 0x3C, visible right after the stop bit, then popped
        drive_rx(8'h3C, 1'b1);
        check("rx_3c_valid_after_stop", rx_valid_o, 1'b1);
        drain_model();

        // RX: random bursts queued, then drained in order
        for (int r = 0; r < 2; r++) begin
            nr = $urandom_range(2, 5);
            for (int i = 0; i < nr; i++) drive_rx(8'($urandom), 1'b1);
            drain_model();
        end
        check_pulses("rx_random");

        // Break and framing errors
        drive_rx(8'h00, 1'b0);
        check_pulses("break");
        drive_rx(8'h55, 1'b0);
        check_pulses("frame_err");
        b = 8'($urandom_range(1, 255));
        drive_rx(b, 1'b0);
        check_pulses("frame_err_rand");

        // Overrun: 17 bytes into a 16-deep FIFO with no consumer
        for (int i = 0; i <= 16; i++) drive_rx(8'(i), 1'b1);
        check_pulses("overrun");
        drain_model();

        // False start: 12-cycle low glitch
        uart_rx_i = 1'b0;
        repeat (12) @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (800) @(negedge clk_i);
        check_pulses("glitch");
        $display("glitch of 12 cycles driven on rx line");

        // Reset in the middle of a TX frame of 0x00 (line low during data)
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        repeat (200) @(negedge clk_i);
        check("mid_frame_line_low", uart_tx_o, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_mid_frame_line", uart_tx_o, 1'b1);
        check("rst_mid_frame_ready", tx_ready_o, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_release_ready", tx_ready_o, 1'b1);
        $display("reset asserted mid tx frame and released");

`ifdef UART_LOOPBACK_EN
        begin
            int zeros;
            loopback_i = 1'b1;
            repeat (4) @(negedge clk_i);
            uart_rx_i = 1'b0;
            tx_data_i  = 8'hC3;
            tx_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            tx_valid_i = 1'b0;
            zeros = 0;
            for (int c = 0; c < 700; c++) begin
                @(negedge clk_i);
                if (uart_tx_o !== 1'b1) zeros++;
            end
            check("loop_tx_held_high", zeros, 0);
            model_q.push_back(8'hC3);
            drain_model();
            uart_rx_i = 1'b1;
            repeat (4) @(negedge clk_i);
            loopback_i = 1'b0;
            $display("loopback byte c3 sent");
        end
`endif

        check_pulses("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Synthesizable 8n1 UART transceiver for the DUT side of the serial link; it is the device-end counterpart to the simulation UART model.
- Uses the same x16 oversampling divisor convention: divisor = SYS_CLK / (BAUD * 16).
- Exposes valid/ready byte streams to on-chip logic and buffers received bytes in a show-ahead FIFO.

Parameters:
RX_FIFO_AW, 4, log2 of RX FIFO depth (default 16 entries); legal range 1..8.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
uart_rx_i  input  1  serial line in (asynchronous)
uart_tx_o  output  1  serial line out, idle high
divisor_i  input  16  strobe divisor
tx_data_i  input  8  byte to send
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  transmitter can accept a byte
rx_data_o  output  8  FIFO head byte
rx_valid_o  output  1  FIFO not empty
rx_ready_i  input  1  consumer pops head
rx_overrun_o  output  1  1-cycle pulse: byte dropped, FIFO full
rx_frame_err_o  output  1  1-cycle pulse: bad stop bit, non-zero data
rx_break_o  output  1  1-cycle pulse: bad stop bit, data 0x00
loopback_i  input  1  internal loopback select (see Optional Feature)

Behaviour:
- Reset values: uart_tx_o=1, tx_ready_o=0 while rst_i high, rx_valid_o=0, all pulse outputs 0; FIFO empty; both FSMs IDLE.
- Reset mid-frame aborts immediately; line returns high the cycle after rst_i is sampled.
- Strobe generator:
  - 16-bit down-counter, loaded with divisor_i-1 on reset and whenever it is 0; strobe = (counter==0).
  - divisor_i=0 wraps to a period of 65536.
  - A divisor_i change takes effect at the next reload.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - tx_ready_o = (state==IDLE) & ~rst_i.
  - Accept on tx_valid_i & tx_ready_o: byte latched, tick counter cleared, uart_tx_o=0 the next cycle.
  - Each bit lasts 16 strobes; the line changes registered on the 16th strobe.
  - Data is sent LSB first, then one stop bit (1).
  - STOP ends on its 16th strobe: state IDLE, tx_ready_o high the following cycle.
  - Frame = 160 strobes; back-to-back frames have no extra idle time.
  - tx_data_i is ignored when not accepted.
- RX input path: uart_rx_i passes through a 2-flop synchronizer.
  - prev_rx is updated on each strobe and reset to 0, so a line held low from reset produces no frame.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, all sampling on strobes.
  - IDLE: on a strobe with sync_rx=0 and prev_rx=1, go to START with tick=0.
  - START: sample at tick 7 (mid-bit). If 1, false start -> IDLE. Else go to DATA; later samples are every 16 strobes.
  - DATA: 8 samples shifted in LSB first.
  - STOP sample = 1: push byte to FIFO.
  - STOP sample = 0 with byte==0x00: rx_break_o pulse, no push.
  - STOP sample = 0 otherwise: rx_frame_err_o pulse, no push.
  - After the stop sample, return to IDLE; edge search resumes on the next strobe.
- RX FIFO:
  - Depth 2^RX_FIFO_AW; occupancy counter RX_FIFO_AW+1 bits wide; pointers wrap naturally.
  - Show-ahead: rx_data_o = head whenever rx_valid_o=1.
  - Pop on rx_valid_o & rx_ready_i.
  - Push while full with no pop: byte dropped, rx_overrun_o pulse, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty is impossible (no pop when empty); push makes rx_valid_o=1 the next cycle.
- At most one of the rx_overrun_o, rx_frame_err_o and rx_break_o pulses is asserted per frame.

Optional Feature:
- UART_LOOPBACK_EN defined, loopback_i=1:
  - Synchronizer input = internal TX line register.
  - uart_tx_o is held 1 and uart_rx_i is ignored.
  - Switching loopback_i mid-frame gives undefined frame contents but no lockup.
- UART_LOOPBACK_EN undefined: loopback_i is unused, with no logic behind it; RX always uses uart_rx_i.

Test Plan:
- TX byte: divisor_i=4, send 0xA5 -> uart_tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles; tx_ready_o low for 640 cycles (±3 strobe phase), then high.
- RX byte: divisor_i=4, drive frame 0x3C at 64 cycles/bit -> rx_valid_o=1, rx_data_o=0x3C within 1 bit time after stop mid-point; pop with rx_ready_i -> rx_valid_o=0.
- Break and framing: drive 0x00 with stop=0 -> rx_break_o one pulse, no push. Drive 0x55 with stop=0 -> rx_frame_err_o one pulse, no push.
- Overrun: RX_FIFO_AW=4, rx_ready_i=0, send 17 bytes 0x00..0x10 -> 16 stored, one rx_overrun_o pulse; popping yields 0x00..0x0F in order.
- False start and reset: 12-cycle low glitch at divisor_i=4 -> no frame, no error pulse. Assert rst_i mid TX frame -> uart_tx_o=1 next cycle, tx_ready_o=1 after release.
- Loopback (UART_LOOPBACK_EN): loopback_i=1, send 0xC3 -> rx_data_o=0xC3, uart_tx_o stays 1 throughout.
